// File: rtl/bloque_serializador.sv
// Receives a {entrada, nonce} block over valid/ready, latches its fields and
// streams it MSB-first as bytes to the hash core over a byte-wide valid/ready link.
module bloque_serializador #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned BYTE_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BLOCK_W-1:0]         bloque_in,
  input  logic                       bloque_valid,
  output logic                       bloque_ready,
  output logic [BYTE_W-1:0]          byte_out,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output logic                       byte_last,
  output logic [BLOCK_W-NONCE_W-1:0] entrada_out,
  output logic [NONCE_W-1:0]         nonce_out,
  output logic                       busy
);

  localparam int unsigned ENTRADA_W = BLOCK_W - NONCE_W;
  localparam int unsigned N_BYTES   = BLOCK_W / BYTE_W;
  localparam int unsigned IDX_W     = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                 r_state;
  logic [BLOCK_W-1:0]     r_shift;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_ready;
  logic [BYTE_W-1:0]      r_byte;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_busy;
  logic [ENTRADA_W-1:0]   r_entrada;
  logic [NONCE_W-1:0]     r_nonce;

  state_t                 w_state_nxt;
  logic [BLOCK_W-1:0]     w_shift_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [ENTRADA_W-1:0]   w_entrada_nxt;
  logic [NONCE_W-1:0]     w_nonce_nxt;
  logic                   w_send_nxt;
  logic [BYTE_W-1:0]      w_byte_nxt;
  logic                   w_last_nxt;

  // Next-state and next-output decode; outputs are registered copies of it,
  // so the handshake inputs never reach a port combinationally.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_idx_nxt     = r_idx;
    w_entrada_nxt = r_entrada;
    w_nonce_nxt   = r_nonce;
    case (r_state)
      ST_IDLE: begin
        // r_ready gates capture so the first cycle out of reset never captures
        if (bloque_valid && r_ready) begin
          w_shift_nxt   = bloque_in;
          w_entrada_nxt = bloque_in[BLOCK_W-1:NONCE_W];
          w_nonce_nxt   = bloque_in[NONCE_W-1:0];
          w_idx_nxt     = '0;
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (byte_ready) begin
          w_shift_nxt = {r_shift[BLOCK_W-BYTE_W-1:0], BYTE_W'(0)};
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_send_nxt = (w_state_nxt == ST_SEND);
    w_byte_nxt = w_send_nxt ? w_shift_nxt[BLOCK_W-1 -: BYTE_W] : '0;
    w_last_nxt = w_send_nxt && (w_idx_nxt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_ready   <= 1'b0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_entrada <= '0;
      r_nonce   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_ready   <= !w_send_nxt;
      r_byte    <= w_byte_nxt;
      r_valid   <= w_send_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_send_nxt;
      r_entrada <= w_entrada_nxt;
      r_nonce   <= w_nonce_nxt;
    end
  end

  assign bloque_ready = r_ready;
  assign byte_out     = r_byte;
  assign byte_valid   = r_valid;
  assign byte_last    = r_last;
  assign entrada_out  = r_entrada;
  assign nonce_out    = r_nonce;
  assign busy         = r_busy;

endmodule
